// File: rtl/reorder_queue_drain_pkg.sv
// Shared derivations and FSM encoding for the reorder queue read side.
package reorder_queue_drain_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  // Ceiling log2 with clog2s(1) == 0.
  function automatic int clog2s(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = int'(i) + 1;
    end
    return r;
  endfunction

  function automatic int num_tags(input int unsigned tag_w);
    return 1 << tag_w;
  endfunction

  function automatic int data_words(input int unsigned data_w);
    return int'(data_w / 32);
  endfunction

endpackage

// File: rtl/reorder_queue_drain_if.sv
// In-order beat stream from the reorder queue drain to the channel logic.
interface reorder_queue_drain_if
  import reorder_queue_drain_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_TAG_WIDTH      = 5
);
  localparam int C_PCI_DATA_WORD = data_words(C_PCI_DATA_WIDTH);

  logic                        OUT_VALID;
  logic                        OUT_READY;
  logic [C_PCI_DATA_WIDTH-1:0] OUT_DATA;
  logic [C_PCI_DATA_WORD-1:0]  OUT_EN;
  logic                        OUT_LAST;
  logic                        OUT_ERR;
  logic [C_TAG_WIDTH-1:0]      OUT_TAG;

  modport master (
    output OUT_VALID, OUT_DATA, OUT_EN, OUT_LAST, OUT_ERR, OUT_TAG,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID, OUT_DATA, OUT_EN, OUT_LAST, OUT_ERR, OUT_TAG,
    output OUT_READY
  );

endinterface

// File: rtl/reorder_queue_drain_buf.sv
// Two-entry valid/ready output FIFO; the head entry is held stable until accepted.
module reorder_queue_drain_buf
  import reorder_queue_drain_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_TAG_WIDTH      = 5,
  localparam int C_PCI_DATA_WORD = data_words(C_PCI_DATA_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [C_PCI_DATA_WIDTH-1:0] push_data,
  input  logic [C_PCI_DATA_WORD-1:0]  push_en,
  input  logic                        push_last,
  input  logic                        push_err,
  input  logic [C_TAG_WIDTH-1:0]      push_tag,
  output logic                        pop,
  output logic [1:0]                  count,
  reorder_queue_drain_if.master       out_if
);
  localparam int EW = C_PCI_DATA_WIDTH + C_PCI_DATA_WORD + 2 + C_TAG_WIDTH;

  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [1:0]    count_q, count_d;
  logic          valid;
  logic [EW-1:0] head_entry;

  assign valid      = (count_q != 2'd0);
  assign pop        = valid & out_if.OUT_READY;
  assign count      = count_q;
  assign head_entry = valid ? mem_q[rd_q] : '0;

  assign out_if.OUT_VALID = valid;
  assign {out_if.OUT_DATA, out_if.OUT_EN, out_if.OUT_LAST, out_if.OUT_ERR, out_if.OUT_TAG} = head_entry;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push) begin
      mem_d[wr_q] = {push_data, push_en, push_last, push_err, push_tag};
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reorder_queue_drain.sv
// Read side of the tag reorder queue: waits for the head tag to finish, streams
// its payload out of the per-DW banks in order, then clears the tag and advances.
module reorder_queue_drain
  import reorder_queue_drain_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH         = 128,
  parameter int C_TAG_WIDTH              = 5,
  parameter int C_TAG_DW_COUNT_WIDTH     = 8,
  parameter int C_DATA_ADDR_STRIDE_WIDTH = 5,
  parameter int C_DATA_ADDR_WIDTH        = 10,
  localparam int C_NUM_TAGS            = num_tags(C_TAG_WIDTH),
  localparam int C_PCI_DATA_WORD       = data_words(C_PCI_DATA_WIDTH),
  localparam int C_PCI_DATA_WORD_WIDTH = clog2s(C_PCI_DATA_WORD)
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [C_NUM_TAGS-1:0]           TAG_FINISH,
  input  logic                            PKT_VALID,
  input  logic [C_TAG_WIDTH-1:0]          PKT_TAG,
  input  logic [C_TAG_DW_COUNT_WIDTH-1:0] PKT_WORDS,
  input  logic                            PKT_DONE,
  input  logic                            PKT_ERR,
  output logic [C_NUM_TAGS-1:0]           TAG_CLEAR,
  output logic                            RAM_REN,
  output logic [C_DATA_ADDR_WIDTH-1:0]    RAM_ADDR,
  input  logic [C_PCI_DATA_WIDTH-1:0]     RAM_DATA,
  reorder_queue_drain_if.master           out_if
);
  localparam int BCW = C_DATA_ADDR_STRIDE_WIDTH + 1;
  localparam int CW  = C_TAG_DW_COUNT_WIDTH;

  state_e                     state_q, state_d;
  logic [C_TAG_WIDTH-1:0]     head_q, head_d;
  logic [C_NUM_TAGS-1:0]      finished_q, finished_d;
  logic [CW-1:0]              words_q [C_NUM_TAGS];
  logic [CW-1:0]              words_d [C_NUM_TAGS];
  logic [C_NUM_TAGS-1:0]      err_q, err_d;
  logic [BCW-1:0]             beats_q, beats_d, beat_q, beat_d;
  logic [C_PCI_DATA_WORD-1:0] last_en_q, last_en_d;
  logic                       cur_err_q, cur_err_d;
  logic [C_NUM_TAGS-1:0]      tag_clear_q, tag_clear_d;
  logic                       pend_q, pend_d, pend_last_q, pend_last_d, pend_err_q, pend_err_d;
  logic [C_PCI_DATA_WORD-1:0] pend_en_q, pend_en_d;
  logic [C_TAG_WIDTH-1:0]     pend_tag_q, pend_tag_d;

  logic                       buf_pop;
  logic [1:0]                 buf_count;
  logic [CW-1:0]              head_words;
  logic [CW:0]                words_rnd;
  logic [BCW-1:0]             beats_calc;
  logic [31:0]                head_rem;
  logic [C_PCI_DATA_WORD-1:0] last_en_calc;
  logic [2:0]                 occ_next;
  logic                       issue, last_issue;
  logic [C_NUM_TAGS-1:0]      head_onehot;
  logic [C_DATA_ADDR_WIDTH-1:0] rd_addr;

  assign head_words   = words_q[head_q];
  assign words_rnd    = {1'b0, head_words} + (CW+1)'(C_PCI_DATA_WORD - 1);
  assign beats_calc   = BCW'(words_rnd >> C_PCI_DATA_WORD_WIDTH);
  assign head_rem     = 32'(head_words) % 32'(C_PCI_DATA_WORD);
  assign last_en_calc = (head_rem == 32'd0) ? '1 : C_PCI_DATA_WORD'((64'd1 << head_rem) - 64'd1);
  assign head_onehot  = C_NUM_TAGS'(1) << head_q;

  // Reads stay combinational so data lands one cycle later and the 2-entry
  // buffer sustains one beat per cycle; in-flight data is counted as occupied.
  assign occ_next   = {1'b0, buf_count} + {2'b0, pend_q} - {2'b0, buf_pop};
  assign issue      = (state_q == S_READ) && (occ_next < 3'd2);
  assign last_issue = (beat_q == beats_q - BCW'(1));
  assign rd_addr    = (C_DATA_ADDR_WIDTH'(head_q) << C_DATA_ADDR_STRIDE_WIDTH) + C_DATA_ADDR_WIDTH'(beat_q);

  assign RAM_REN   = issue;
  assign RAM_ADDR  = issue ? rd_addr : '0;
  assign TAG_CLEAR = tag_clear_q;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    beats_d     = beats_q;
    beat_d      = beat_q;
    last_en_d   = last_en_q;
    cur_err_d   = cur_err_q;
    tag_clear_d = '0;
    words_d     = words_q;
    err_d       = err_q;
    finished_d  = (finished_q | TAG_FINISH) & ~tag_clear_q;
    if (PKT_VALID && (PKT_DONE || PKT_ERR)) begin
      words_d[PKT_TAG] = PKT_WORDS;
      err_d[PKT_TAG]   = PKT_ERR;
    end
    pend_d      = issue;
    pend_last_d = issue && last_issue;
    pend_en_d   = last_issue ? last_en_q : '1;
    pend_err_d  = cur_err_q;
    pend_tag_d  = head_q;
    unique case (state_q)
      S_IDLE: begin
        if (finished_q[head_q]) begin
          beats_d   = beats_calc;
          beat_d    = '0;
          last_en_d = last_en_calc;
          cur_err_d = err_q[head_q];
          if (head_words == '0) begin
            state_d     = S_CLEAR;
            tag_clear_d = head_onehot;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          beat_d = beat_q + 1'b1;
          if (last_issue) begin
            state_d     = S_CLEAR;
            tag_clear_d = head_onehot;
          end
        end
      end
      S_CLEAR: begin
        head_d  = head_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      finished_q  <= '0;
      words_q     <= '{default: '0};
      err_q       <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      last_en_q   <= '0;
      cur_err_q   <= 1'b0;
      tag_clear_q <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_en_q   <= '0;
      pend_err_q  <= 1'b0;
      pend_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      finished_q  <= finished_d;
      words_q     <= words_d;
      err_q       <= err_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      last_en_q   <= last_en_d;
      cur_err_q   <= cur_err_d;
      tag_clear_q <= tag_clear_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      pend_en_q   <= pend_en_d;
      pend_err_q  <= pend_err_d;
      pend_tag_q  <= pend_tag_d;
    end
  end

  reorder_queue_drain_buf #(
    .C_PCI_DATA_WIDTH (C_PCI_DATA_WIDTH),
    .C_TAG_WIDTH      (C_TAG_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (pend_q),
    .push_data (RAM_DATA),
    .push_en   (pend_en_q),
    .push_last (pend_last_q),
    .push_err  (pend_err_q),
    .push_tag  (pend_tag_q),
    .pop       (buf_pop),
    .count     (buf_count),
    .out_if    (out_if)
  );

endmodule

// File: tb/tb_reorder_queue_drain.sv
// Directed bench for reorder_queue_drain: per-tag expected beats, addresses and
// clears are generated from tag/word counts and checked every cycle.
module tb_reorder_queue_drain;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [31:0]  TAG_FINISH;
  logic         PKT_VALID;
  logic [4:0]   PKT_TAG;
  logic [7:0]   PKT_WORDS;
  logic         PKT_DONE;
  logic         PKT_ERR;
  logic [31:0]  TAG_CLEAR;
  logic         RAM_REN;
  logic [9:0]   RAM_ADDR;
  logic [127:0] RAM_DATA = '0;

  reorder_queue_drain_if #(.C_PCI_DATA_WIDTH(128), .C_TAG_WIDTH(5)) out_if ();

  reorder_queue_drain #(
    .C_PCI_DATA_WIDTH         (128),
    .C_TAG_WIDTH              (5),
    .C_TAG_DW_COUNT_WIDTH     (8),
    .C_DATA_ADDR_STRIDE_WIDTH (5),
    .C_DATA_ADDR_WIDTH        (10)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .TAG_FINISH (TAG_FINISH),
    .PKT_VALID  (PKT_VALID),
    .PKT_TAG    (PKT_TAG),
    .PKT_WORDS  (PKT_WORDS),
    .PKT_DONE   (PKT_DONE),
    .PKT_ERR    (PKT_ERR),
    .TAG_CLEAR  (TAG_CLEAR),
    .RAM_REN    (RAM_REN),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_DATA   (RAM_DATA),
    .out_if     (out_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   en;
    logic         last;
    logic         err;
    logic [4:0]   tag;
  } beat_t;

  beat_t       exp_beats[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_clr[$];
  logic [9:0]  addr_log[$];
  logic [31:0] clr_log[$];
  logic [3:0]  last_en_seen;
  logic        err_seen;
  int unsigned beat_cnt;
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic [127:0] pat(input logic [9:0] a);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) r[i*32 +: 32] = 32'hC0DE_0000 | (32'(a) << 4) | i;
    return r;
  endfunction

  // Bank model: DW i at address a holds pat(a), one-cycle read latency.
  always @(posedge CLK) if (RAM_REN) RAM_DATA <= pat(RAM_ADDR);

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [191:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic expect_tag(input int unsigned t, input int unsigned w, input bit e);
    int unsigned nb;
    nb = (w + 3) / 4;
    for (int unsigned b = 0; b < nb; b++) begin
      beat_t x;
      logic [9:0] a;
      a      = 10'(t * 32 + b);
      x.data = pat(a);
      x.en   = (b == nb - 1 && (w % 4) != 0) ? 4'((1 << (w % 4)) - 1) : 4'hF;
      x.last = (b == nb - 1);
      x.err  = e;
      x.tag  = 5'(t);
      exp_beats.push_back(x);
      exp_addr.push_back(a);
    end
    exp_clr.push_back(32'd1 << t);
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (RAM_REN) begin
        addr_log.push_back(RAM_ADDR);
        if (exp_addr.size() == 0) fail("ram_addr_extra", RAM_ADDR);
        else chk("ram_addr", RAM_ADDR, exp_addr.pop_front());
      end
      if (TAG_CLEAR != '0) begin
        clr_log.push_back(TAG_CLEAR);
        if (exp_clr.size() == 0) fail("tag_clear_extra", TAG_CLEAR);
        else chk("tag_clear", TAG_CLEAR, exp_clr.pop_front());
      end
      if (out_if.OUT_VALID && out_if.OUT_READY) begin
        beat_cnt++;
        last_en_seen = out_if.OUT_EN;
        err_seen     = out_if.OUT_ERR;
        if (exp_beats.size() == 0) fail("beat_extra", out_if.OUT_DATA);
        else begin
          beat_t x;
          x = exp_beats.pop_front();
          chk("beat", {out_if.OUT_DATA, out_if.OUT_EN, out_if.OUT_LAST, out_if.OUT_ERR, out_if.OUT_TAG},
              {x.data, x.en, x.last, x.err, x.tag});
        end
      end
    end
  end

  task automatic finish_tag(input int unsigned t, input int unsigned w, input bit e);
    TAG_FINISH = 32'd1 << t;
    PKT_VALID  = 1'b1;
    PKT_TAG    = 5'(t);
    PKT_WORDS  = 8'(w);
    PKT_DONE   = 1'b1;
    PKT_ERR    = e;
    @(posedge CLK); #1;
    TAG_FINISH = '0;
    PKT_VALID  = 1'b0;
    PKT_DONE   = 1'b0;
    PKT_ERR    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int unsigned i = 0; i < 600 && !done; i++) begin
      @(posedge CLK); #1;
      if (exp_beats.size() == 0 && exp_addr.size() == 0 && exp_clr.size() == 0 && !out_if.OUT_VALID)
        done = 1'b1;
    end
    if (!done) fail({name, "_timeout"}, 192'(exp_beats.size()));
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic new_phase();
    addr_log.delete();
    clr_log.delete();
    beat_cnt = 0;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {TAG_CLEAR, RAM_REN, RAM_ADDR, out_if.OUT_VALID, out_if.OUT_DATA, out_if.OUT_EN,
               out_if.OUT_LAST, out_if.OUT_ERR, out_if.OUT_TAG}, '0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1 chk_zero("reset_outputs");
    exp_beats.delete();
    exp_addr.delete();
    exp_clr.delete();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] snap;
    RST_N = 1'b0;
    TAG_FINISH = '0; PKT_VALID = 1'b0; PKT_TAG = '0; PKT_WORDS = '0; PKT_DONE = 1'b0; PKT_ERR = 1'b0;
    out_if.OUT_READY = 1'b1;
    beat_cnt = 0;
    repeat (3) @(posedge CLK);
    #1 chk_zero("reset_state");
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Tag 0, 10 words: three beats, last enable 0011.
    new_phase();
    expect_tag(0, 10, 1'b0);
    finish_tag(0, 10, 1'b0);
    wait_drain("tag0_10w");
    chk("a_beats", 192'(beat_cnt), 192'd3);
    chk("a_addr2", 192'(addr_log.size() > 2 ? addr_log[2] : 10'h3ff), 192'd2);
    chk("a_last_en", 192'(last_en_seen), 192'h3);
    chk("a_clear", 192'(clr_log.size() > 0 ? clr_log[0] : 32'h0), 192'h1);

    // Tag 1, 18 words with the consumer stalled.
    new_phase();
    out_if.OUT_READY = 1'b0;
    expect_tag(1, 18, 1'b0);
    finish_tag(1, 18, 1'b0);
    repeat (8) @(posedge CLK);
    #1;
    chk("stall_reads", 192'(addr_log.size()), 192'd2);
    chk("stall_ren", 192'(RAM_REN), 192'd0);
    chk("stall_valid", 192'(out_if.OUT_VALID), 192'd1);
    snap = out_if.OUT_DATA;
    chk("stall_data", 192'(snap), 192'(pat(10'd32)));
    repeat (3) @(posedge CLK);
    #1 chk("stall_stable", 192'(out_if.OUT_DATA), 192'(snap));
    out_if.OUT_READY = 1'b1;
    wait_drain("stall");
    chk("stall_beats", 192'(beat_cnt), 192'd5);

    // Tag 2 with error.
    new_phase();
    expect_tag(2, 4, 1'b1);
    finish_tag(2, 4, 1'b1);
    wait_drain("err");
    chk("err_beats", 192'(beat_cnt), 192'd1);
    chk("err_flag", 192'(err_seen), 192'd1);

    // Zero-word tags 3..30 advance the head with clears only.
    new_phase();
    for (int unsigned t = 3; t <= 30; t++) begin
      expect_tag(t, 0, 1'b0);
      finish_tag(t, 0, 1'b0);
    end
    wait_drain("zero_words");
    chk("zero_beats", 192'(beat_cnt), 192'd0);
    chk("zero_clears", 192'(clr_log.size()), 192'd28);

    // Head 31 then wrap to a tag 0 that finished earlier.
    new_phase();
    expect_tag(31, 4, 1'b0);
    expect_tag(0, 4, 1'b0);
    finish_tag(0, 4, 1'b0);
    finish_tag(31, 4, 1'b0);
    wait_drain("wrap");
    chk("wrap_addr", 192'(addr_log.size() > 0 ? addr_log[0] : 10'h0), 192'd992);
    chk("wrap_clear", 192'(clr_log.size() > 0 ? clr_log[0] : 32'h0), 192'h8000_0000);
    chk("wrap_clear0", 192'(clr_log.size() > 1 ? clr_log[1] : 32'h0), 192'h1);

    // Out-of-order finish after reset: tag 1 must wait for tag 0.
    do_reset();
    new_phase();
    expect_tag(0, 8, 1'b0);
    expect_tag(1, 4, 1'b0);
    finish_tag(1, 4, 1'b0);
    repeat (8) @(posedge CLK);
    #1;
    chk("ooo_wait_valid", 192'(out_if.OUT_VALID), 192'd0);
    chk("ooo_wait_reads", 192'(addr_log.size()), 192'd0);
    finish_tag(0, 8, 1'b0);
    wait_drain("ooo");
    chk("ooo_addr", 192'(addr_log.size() > 2 ? addr_log[2] : 10'h0), 192'd32);
    chk("ooo_clear", 192'(clr_log.size() > 1 ? clr_log[1] : 32'h0), 192'h2);

    // Reset in the middle of draining tag 2.
    new_phase();
    expect_tag(2, 20, 1'b0);
    finish_tag(2, 20, 1'b0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_zero("midread_reset");
    exp_beats.delete();
    exp_addr.delete();
    exp_clr.delete();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    new_phase();
    repeat (20) @(posedge CLK);
    #1;
    chk("post_reset_reads", 192'(addr_log.size()), 192'd0);
    chk("post_reset_clears", 192'(clr_log.size()), 192'd0);
    expect_tag(0, 4, 1'b0);
    finish_tag(0, 4, 1'b0);
    wait_drain("post_reset");
    chk("post_reset_head", 192'(addr_log.size() > 0 ? addr_log[0] : 10'h3ff), 192'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_queue_drain.md
Name: reorder_queue_drain

Overview:
- Read side of the tag reorder queue; the reorder input stage is the write side.
- Watches per-tag finish events from the input stage and waits for the in-order head tag to complete.
- Reads that tag's payload out of the C_PCI_DATA_WORD per-DW RAM banks and presents it as an in-order valid/ready beat stream to the channel logic.
- Pulses TAG_CLEAR so the input stage resets that tag's count and positions, then advances the head tag.

Parameters:
- C_PCI_DATA_WIDTH, 128: payload width in bits.
- C_TAG_WIDTH, 5: tag width; C_NUM_TAGS = 2**C_TAG_WIDTH.
- C_TAG_DW_COUNT_WIDTH, 8: width of the per-tag DW count.
- C_DATA_ADDR_STRIDE_WIDTH, 5: width of the per-tag position within one bank.
- C_DATA_ADDR_WIDTH, 10: bank address width. Address = (tag<<C_DATA_ADDR_STRIDE_WIDTH) + beat.
- Local: C_PCI_DATA_WORD = C_PCI_DATA_WIDTH/32; C_PCI_DATA_WORD_WIDTH = clog2s(C_PCI_DATA_WORD).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- TAG_FINISH  in  C_NUM_TAGS  bitmap of tags finished this cycle.
- PKT_VALID  in  1  input-stage packet info valid.
- PKT_TAG  in  C_TAG_WIDTH  tag of the packet info.
- PKT_WORDS  in  C_TAG_DW_COUNT_WIDTH  cumulative DW count for the tag.
- PKT_DONE  in  1  tag complete.
- PKT_ERR  in  1  tag completed with error.
- TAG_CLEAR  out  C_NUM_TAGS  one-hot, one-cycle clear pulse.
- RAM_REN  out  1  bank read enable, common to all banks.
- RAM_ADDR  out  C_DATA_ADDR_WIDTH  bank read address, common to all banks.
- RAM_DATA  in  C_PCI_DATA_WIDTH  bank read data; DW i comes from bank i; 1-cycle latency.
- OUT_VALID  out  1  beat valid.
- OUT_READY  in  1  consumer accepts the beat.
- OUT_DATA  out  C_PCI_DATA_WIDTH  beat payload.
- OUT_EN  out  C_PCI_DATA_WORD  per-DW enable.
- OUT_LAST  out  1  final beat of the tag.
- OUT_ERR  out  1  tag had an error.
- OUT_TAG  out  C_TAG_WIDTH  tag of the beat.

Behaviour:
- Reset: RST_N low asynchronously clears all state. Outputs are 0: TAG_CLEAR, RAM_REN, RAM_ADDR, OUT_*. Head tag = 0, finished bitmap = 0, state IDLE, output buffer empty.
- Bookkeeping:
  - rFinished <= (rFinished | TAG_FINISH) & ~TAG_CLEAR.
  - On PKT_VALID & (PKT_DONE | PKT_ERR), store PKT_WORDS and PKT_ERR in per-tag registers indexed by PKT_TAG. These arrive in the same cycle as the matching TAG_FINISH bit.
- State machine:
  - IDLE: if rFinished[head], latch words/err for head, compute beats = ceil(words / C_PCI_DATA_WORD), set beat counter = 0, go to READ next cycle. If words == 0, go to CLEAR directly; no beats are emitted.
  - READ: assert RAM_REN with RAM_ADDR = (head<<C_DATA_ADDR_STRIDE_WIDTH) + beat only when buffer space allows. Increment beat on each issue. After issuing beat beats-1, go to CLEAR.
  - CLEAR: for one cycle, TAG_CLEAR = 1<<head. Clear rFinished[head]. head <= head+1, wrapping from C_NUM_TAGS-1 to 0. Go to IDLE.
- Minimum gap between consecutive tags is 2 cycles (CLEAR, IDLE).
- Read issue rule: issue only if (buffer occupancy − pop this cycle + reads in flight) < 2. This gives full throughput when OUT_READY = 1 and never overflows.
- Output buffer: 2-entry FIFO. Each entry holds data, enable, last, err and tag. RAM_DATA is written one cycle after RAM_REN.
  - OUT_EN = all ones, except on the last beat, where it is the low (words mod C_PCI_DATA_WORD) bits set; if words mod C_PCI_DATA_WORD is 0, it is all ones.
  - OUT_LAST is set on the last beat only.
  - OUT_ERR equals the latched err on every beat of the tag.
- Handshake: a beat transfers when OUT_VALID & OUT_READY. While not accepted, the beat and all its fields stay stable; OUT_VALID does not drop.
- Simultaneous events:
  - TAG_FINISH for head arriving in IDLE is honoured one cycle later, after the register update.
  - TAG_FINISH for non-head tags only accumulates.
  - A TAG_FINISH bit for a tag being cleared in the same cycle is dropped by the clear mask. This cannot legally happen.
- Width rules: beat counter is C_DATA_ADDR_STRIDE_WIDTH+1 bits. Words > C_PCI_DATA_WORD<<C_DATA_ADDR_STRIDE_WIDTH is illegal; no checking is done.
- Reset mid-drain: everything is discarded. No TAG_CLEAR is issued; the input stage is reset together with this block.

Decomposition:
- Shared package: C_NUM_TAGS and C_PCI_DATA_WORD derivations, clog2s, and state encodings (IDLE=0, READ=1, CLEAR=2).
- One sub-module: reorder_queue_drain_buf, the 2-entry valid/ready output FIFO.

Test Plan:
- Tag 0 finishes with 10 words (C_PCI_DATA_WORD=4):
  - RAM_ADDR 0, 1, 2.
  - 3 beats with OUT_EN 1111, 1111, 0011; OUT_LAST on beat 3.
  - TAG_CLEAR = 0x1 for one cycle; head becomes 1.
- Tag 1 finishes (4 words) before tag 0 (8 words):
  - No output until tag 0 finishes.
  - Then tag 0 at addresses 0–1, followed by tag 1 at address 32.
  - TAG_CLEAR 0x1 then 0x2.
- OUT_READY held low during a 5-beat tag:
  - At most 2 reads issued, RAM_REN then held 0, OUT_DATA stable.
  - After release, all 5 beats arrive in order with no loss or duplication.
- Head = 31 finishes with 4 words:
  - Reads address 992; TAG_CLEAR = 1<<31.
  - Head wraps to 0; a finished tag 0 drains next.
- Tag 2 finishes with PKT_ERR=1 and 4 words: one beat with OUT_ERR=1 and OUT_LAST=1. A zero-word finished tag produces no beats, only TAG_CLEAR.
- RST_N pulsed low mid-READ:
  - Outputs 0 immediately.
  - After release, head = 0, no stale beats or clears.
